// File: rtl/denoise_mode_ctrl.sv
// denoise_mode_ctrl: sequences the shared denoise datapath. It owns the
// median/gaussian mux select, issues 4-block groups into the engines, tracks
// in-flight groups, and performs drain-then-flip mode switches so that no
// output group mixes engines. It also counts output groups per frame.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   in_valid        upstream group valid
//   in_ready        controller accepts a group this cycle
//   eng_valid       issue strobe to both engines (in_valid & in_ready)
//   out_valid       mux output group valid this cycle
//   mode_req        requested mode (0 median, 1 gaussian)
//   mode_req_valid  mode change request
//   mode_req_ready  request accepted this cycle
//   mode            mux select (0 median, 1 gaussian)
//   switch_done     one-cycle pulse when a switch completes
//   grp_cnt         output groups seen in the current frame
//   frame_done      pulse on the last group of a frame
//   busy            not in RUN, or any group in flight
module denoise_mode_ctrl #(
    parameter int unsigned M_LAT      = 4,
    parameter int unsigned G_LAT      = 3,
    parameter int unsigned FRAME_GRPS = 1024,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             eng_valid,
    output logic             out_valid,
    input  logic             mode_req,
    input  logic             mode_req_valid,
    output logic             mode_req_ready,
    output logic             mode,
    output logic             switch_done,
    output logic [CNT_W-1:0] grp_cnt,
    output logic             frame_done,
    output logic             busy
);

    localparam int unsigned DEPTH = (M_LAT > G_LAT) ? M_LAT : G_LAT;
    // Taps [LAT-1:0] of the in-flight register for each engine.
    localparam logic [DEPTH-1:0] M_MASK   = DEPTH'((1 << M_LAT) - 1);
    localparam logic [DEPTH-1:0] G_MASK   = DEPTH'((1 << G_LAT) - 1);
    localparam logic [CNT_W-1:0] LAST_GRP = CNT_W'(FRAME_GRPS - 1);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        SWITCH = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             mode_nxt;
    logic             target;
    logic             target_nxt;
    logic [DEPTH-1:0] vld_sr;
    logic             pipe_empty;

    // State, mode and target registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= RUN;
            mode   <= 1'b0;
            target <= 1'b0;
        end else begin
            state  <= state_nxt;
            mode   <= mode_nxt;
            target <= target_nxt;
        end
    end

    // In-flight tracking: one bit per issued group, shifted each cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_sr <= '0;
        end else begin
            vld_sr[0] <= eng_valid;
            for (int i = 1; i < int'(DEPTH); i++) begin
                vld_sr[i] <= vld_sr[i-1];
            end
        end
    end

    // Group counter, wraps after the last group of a frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            grp_cnt <= '0;
        end else if (out_valid) begin
            grp_cnt <= (grp_cnt == LAST_GRP) ? '0 : grp_cnt + CNT_W'(1);
        end
    end

    // Output tap and drain test follow the currently selected engine.
    always_comb begin
        out_valid  = mode ? vld_sr[G_LAT-1] : vld_sr[M_LAT-1];
        pipe_empty = mode ? ~|(vld_sr & G_MASK) : ~|(vld_sr & M_MASK);
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_nxt      = state;
        mode_nxt       = mode;
        target_nxt     = target;
        in_ready       = 1'b0;
        mode_req_ready = 1'b0;
        switch_done    = 1'b0;
        case (state)
            RUN: begin
                in_ready       = 1'b1;
                mode_req_ready = 1'b1;
                if (mode_req_valid && (mode_req != mode)) begin
                    target_nxt = mode_req;
                    state_nxt  = DRAIN;
                end
            end
            DRAIN: begin
                // Flip only once the old engine has nothing left to emit.
                if (pipe_empty) begin
                    mode_nxt  = target;
                    state_nxt = SWITCH;
                end
            end
            SWITCH: begin
                switch_done = 1'b1;
                state_nxt   = RUN;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
        eng_valid  = in_valid & in_ready;
        frame_done = out_valid & (grp_cnt == LAST_GRP);
        busy       = (state != RUN) | (|vld_sr);
    end

endmodule

// File: tb/tb_denoise_mode_ctrl.sv
// Bench for denoise_mode_ctrl: directed scenarios followed by a random run,
// checked every cycle against an issue-history reference model. A second
// instance with a 4-group frame exercises the frame counter wrap.
module tb_denoise_mode_ctrl;

    localparam int unsigned M_LAT = 4;
    localparam int unsigned G_LAT = 3;
    localparam int unsigned FG_A  = 1024;
    localparam int unsigned FG_B  = 4;
    localparam int          DEPTH = 4;
    localparam int          MAXC  = 4096;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, mode_req, mode_req_valid;
    logic        in_ready, eng_valid, out_valid, mode_req_ready, mode;
    logic        switch_done, frame_done, busy;
    logic [15:0] grp_cnt;
    logic        in_ready_b, eng_valid_b, out_valid_b, mode_req_ready_b, mode_b;
    logic        switch_done_b, frame_done_b, busy_b;
    logic [2:0]  grp_cnt_b;

    denoise_mode_ctrl #(.M_LAT(M_LAT), .G_LAT(G_LAT), .FRAME_GRPS(FG_A), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .eng_valid(eng_valid), .out_valid(out_valid), .mode_req(mode_req),
        .mode_req_valid(mode_req_valid), .mode_req_ready(mode_req_ready),
        .mode(mode), .switch_done(switch_done), .grp_cnt(grp_cnt),
        .frame_done(frame_done), .busy(busy)
    );

    denoise_mode_ctrl #(.M_LAT(M_LAT), .G_LAT(G_LAT), .FRAME_GRPS(FG_B), .CNT_W(3)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
        .eng_valid(eng_valid_b), .out_valid(out_valid_b), .mode_req(mode_req),
        .mode_req_valid(mode_req_valid), .mode_req_ready(mode_req_ready_b),
        .mode(mode_b), .switch_done(switch_done_b), .grp_cnt(grp_cnt_b),
        .frame_done(frame_done_b), .busy(busy_b)
    );

    // Reference model: phase 0 run, 1 drain, 2 switch; hist[c] = group issued at c.
    int cyc = 0;
    int reset_cyc = 0;
    bit hist[MAXC];
    int m_phase = 0, m_mode = 0, m_target = 0, m_cnt_a = 0, m_cnt_b = 0;
    int n_chk = 0, n_fail = 0;
    int fd_b_seen = 0;

    function automatic bit issued_at(int c);
        if (c < 0 || c < reset_cyc || c >= cyc) return 1'b0;
        return hist[c];
    endfunction

    function automatic bit any_issued(int lo, int hi);
        for (int c = lo; c <= hi; c++) begin
            if (issued_at(c)) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // One clock cycle: inputs are already driven; check, then advance the model.
    task automatic step();
        int lat;
        bit e_ready, e_eng, e_out, e_sw, e_busy, e_fd_a, e_fd_b, empty;
        lat     = (m_mode != 0) ? G_LAT : M_LAT;
        e_ready = (m_phase == 0);
        e_eng   = in_valid && e_ready;
        e_out   = issued_at(cyc - lat);
        e_sw    = (m_phase == 2);
        e_busy  = (m_phase != 0) || any_issued(cyc - DEPTH, cyc - 1);
        e_fd_a  = e_out && (m_cnt_a == FG_A - 1);
        e_fd_b  = e_out && (m_cnt_b == FG_B - 1);
        #3;
        check("in_ready", 32'(in_ready), 32'(e_ready));
        check("mode_req_ready", 32'(mode_req_ready), 32'(e_ready));
        check("eng_valid", 32'(eng_valid), 32'(e_eng));
        check("out_valid", 32'(out_valid), 32'(e_out));
        check("mode", 32'(mode), 32'(m_mode));
        check("switch_done", 32'(switch_done), 32'(e_sw));
        check("grp_cnt", 32'(grp_cnt), 32'(m_cnt_a));
        check("frame_done", 32'(frame_done), 32'(e_fd_a));
        check("busy", 32'(busy), 32'(e_busy));
        check("b_out_valid", 32'(out_valid_b), 32'(e_out));
        check("b_grp_cnt", 32'(grp_cnt_b), 32'(m_cnt_b));
        check("b_frame_done", 32'(frame_done_b), 32'(e_fd_b));
        if (frame_done_b) fd_b_seen++;
        @(posedge clk);
        hist[cyc] = rst ? 1'b0 : e_eng;
        if (rst) begin
            m_phase   = 0;
            m_mode    = 0;
            m_target  = 0;
            m_cnt_a   = 0;
            m_cnt_b   = 0;
            reset_cyc = cyc + 1;
        end else begin
            if (e_out) begin
                m_cnt_a = (m_cnt_a == FG_A - 1) ? 0 : m_cnt_a + 1;
                m_cnt_b = (m_cnt_b == FG_B - 1) ? 0 : m_cnt_b + 1;
            end
            case (m_phase)
                0: if (mode_req_valid && (int'(mode_req) != m_mode)) begin
                    m_target = int'(mode_req);
                    m_phase  = 1;
                end
                1: begin
                    empty = !any_issued(cyc - lat, cyc - 1);
                    if (empty) begin
                        m_mode  = m_target;
                        m_phase = 2;
                    end
                end
                default: m_phase = 0;
            endcase
        end
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    // Present a request and hold it until accepted, bounded.
    task automatic req_hold(input bit m);
        bit acc;
        int waited;
        acc = 1'b0;
        waited = 0;
        mode_req_valid = 1'b1;
        mode_req = m;
        while (!acc && waited < 20) begin
            acc = (m_phase == 0);
            step();
            waited++;
        end
        mode_req_valid = 1'b0;
        check("req_accept_timeout", 32'(acc), 32'd1);
    endtask

    initial begin
        bit pend;
        bit acc;
        int fd0;
        rst = 1'b1; in_valid = 1'b0; mode_req = 1'b0; mode_req_valid = 1'b0;
        #1;
        step(); step();
        rst = 1'b0;
        check("reset_mode", 32'(mode), 32'd0);
        check("reset_cnt", 32'(grp_cnt), 32'd0);

        // Five back-to-back median groups.
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) step();
        idle(8);
        check("s1_grp_cnt", 32'(grp_cnt), 32'd5);
        check("s1_busy", 32'(busy), 32'd0);

        // Switch to gaussian with an empty pipeline, then one group.
        req_hold(1'b1);
        idle(2);
        check("s2_mode", 32'(mode), 32'd1);
        in_valid = 1'b1;
        step();
        idle(6);

        // Back to median, then two groups plus a group with a switch request.
        req_hold(1'b0);
        idle(2);
        in_valid = 1'b1;
        step(); step();
        mode_req_valid = 1'b1; mode_req = 1'b1;
        step();
        mode_req_valid = 1'b0;
        idle(10);
        check("s3_mode", 32'(mode), 32'd1);

        // Request equal to the current mode.
        req_hold(1'b1);
        idle(3);

        // Frame wrap on the 4-group instance.
        rst = 1'b1; step(); rst = 1'b0;
        fd0 = fd_b_seen;
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) step();
        idle(8);
        check("s5_frame_pulses", 32'(fd_b_seen - fd0), 32'd1);
        check("s5_grp_cnt_b", 32'(grp_cnt_b), 32'd2);

        // Reset during drain with groups in flight.
        in_valid = 1'b1;
        step();
        mode_req_valid = 1'b1; mode_req = 1'b1;
        step();
        mode_req_valid = 1'b0; in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("s6_mode", 32'(mode), 32'd0);
        check("s6_grp_cnt", 32'(grp_cnt), 32'd0);
        check("s6_in_ready", 32'(in_ready), 32'd1);
        idle(6);

        // Random traffic, requests held until accepted, occasional reset.
        pend = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            in_valid = ($urandom_range(0, 9) < 7);
            if (!pend && $urandom_range(0, 9) == 0) begin
                pend = 1'b1;
                mode_req = 1'($urandom_range(0, 1));
            end
            mode_req_valid = pend;
            rst = ($urandom_range(0, 199) == 0);
            acc = pend && (m_phase == 0);
            step();
            if (acc) pend = 1'b0;
        end
        rst = 1'b0; mode_req_valid = 1'b0;
        idle(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
